// File: rtl/plan_scan_ctrl.sv
// plan_scan_ctrl: holds a small table of subscription plans and, on request,
// scans it one plan per cycle to pick the eligible plan with the highest
// weighted score (talk*r1 + data*r2). The result is published with a one-cycle
// done pulse and held until the next result.
//
// Handshake: start is a level request that is sampled only in IDLE. No queue is
// kept. busy is high for exactly the NPLAN scan cycles. done is high for one
// cycle when sel/none/best_score take their new values.
module plan_scan_ctrl #(
  parameter int NPLAN = 5,
  parameter int DW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             plan_we,
  input  logic [2:0]       plan_idx,
  input  logic [DW-1:0]    plan_cost,
  input  logic [DW-1:0]    plan_talk,
  input  logic [DW-1:0]    plan_data,
  input  logic [2:0]       r1,
  input  logic [2:0]       r2,
  input  logic [DW-1:0]    budjet,
  input  logic [DW-1:0]    avgtalk,
  input  logic [DW-1:0]    avgdata,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [NPLAN-1:0] sel,
  output logic             none,
  output logic [15:0]      best_score,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Plan table
  logic [DW-1:0] cost_t [NPLAN];
  logic [DW-1:0] talk_t [NPLAN];
  logic [DW-1:0] data_t [NPLAN];

  // Scan parameters, frozen for the duration of a scan
  logic [2:0]    r1_q;
  logic [2:0]    r2_q;
  logic [DW-1:0] bud_q;
  logic [DW-1:0] at_q;
  logic [DW-1:0] ad_q;

  // Scan progress and running best
  logic [2:0]  idx;
  logic        found;
  logic [15:0] run_score;
  logic [2:0]  run_idx;

  // Entry under evaluation and its score
  logic [DW-1:0] cur_cost;
  logic [DW-1:0] cur_talk;
  logic [DW-1:0] cur_data;
  logic [15:0]   score;
  logic          eligible;
  logic          better;
  logic          last;

  assign state_dbg = state;

  // Select the table entry addressed by the scan index
  always_comb begin
    cur_cost = '1;
    cur_talk = '0;
    cur_data = '0;
    for (int i = 0; i < NPLAN; i++) begin
      if (idx == 3'(i)) begin
        cur_cost = cost_t[i];
        cur_talk = talk_t[i];
        cur_data = data_t[i];
      end
    end
  end

  // One shared multiply-add plus the eligibility and improvement tests
  always_comb begin
    score    = 16'(cur_talk) * 16'(r1_q) + 16'(cur_data) * 16'(r2_q);
    eligible = (cur_cost <= bud_q) && (cur_talk >= at_q) && (cur_data >= ad_q);
    // Strictly greater keeps the lower index on ties; the first eligible
    // plan is always taken, even with a zero score.
    better   = eligible && (!found || (score > run_score));
    last     = (idx == 3'(NPLAN - 1));
  end

  // Table writes, accepted whenever a scan is not running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPLAN; i++) begin
        cost_t[i] <= '1;
        talk_t[i] <= '0;
        data_t[i] <= '0;
      end
    end else if (plan_we && (state != SCAN)) begin
      for (int i = 0; i < NPLAN; i++) begin
        if (plan_idx == 3'(i)) begin
          cost_t[i] <= plan_cost;
          talk_t[i] <= plan_talk;
          data_t[i] <= plan_data;
        end
      end
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      sel        <= '0;
      none       <= 1'b1;
      best_score <= '0;
      idx        <= '0;
      found      <= 1'b0;
      run_score  <= '0;
      run_idx    <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
      bud_q      <= '0;
      at_q       <= '0;
      ad_q       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SCAN;
            busy      <= 1'b1;
            idx       <= '0;
            found     <= 1'b0;
            run_score <= '0;
            run_idx   <= '0;
            r1_q      <= r1;
            r2_q      <= r2;
            bud_q     <= budjet;
            at_q      <= avgtalk;
            ad_q      <= avgdata;
          end
        end
        SCAN: begin
          if (better) begin
            found     <= 1'b1;
            run_score <= score;
            run_idx   <= idx;
          end
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        DONE: begin
          state      <= IDLE;
          done       <= 1'b1;
          none       <= !found;
          best_score <= found ? run_score : 16'd0;
          for (int i = 0; i < NPLAN; i++) begin
            sel[i] <= found && (run_idx == 3'(i));
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/plan_scan_ctrl.md
PLAN_SCAN_CTRL -- requirements
Module: plan_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NPLAN, default 5, number of subscription plan slots (range 2..8).
REQ-002 The block SHALL have parameter DW, default 6, width of plan cost/talk/data and user limit fields.
REQ-003 Port clk, input, 1: single rising-edge clock.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port plan_we, input, 1: write strobe for the plan table.
REQ-006 Port plan_idx, input, 3: plan slot written; values >= NPLAN ignored.
REQ-007 Port plan_cost / plan_talk / plan_data, input, DW each: monthly cost, talk allowance, data allowance.
REQ-008 Port r1 / r2, input, 3 each: talk weight / data weight.
REQ-009 Port budjet / avgtalk / avgdata, input, DW each: user budget, average talk, average data.
REQ-010 Port start, input, 1: scan request, sampled only in IDLE.
REQ-011 Port busy, output, 1: high in SCAN.
REQ-012 Port done, output, 1: one-cycle pulse when a result is published.
REQ-013 Port sel, output, NPLAN: one-hot winning plan; all-zero when none eligible.
REQ-014 Port none, output, 1: no plan eligible.
REQ-015 Port best_score, output, 16: score of winning plan; 0 when none.

Function
REQ-016 The block SHALL hold an NPLAN-entry table; a write with plan_we=1 updates the entry at the next clk edge only while not busy; writes during SCAN are dropped.
REQ-017 The FSM SHALL have states IDLE, SCAN, DONE; reset state IDLE.
REQ-018 IDLE->SCAN on start=1; on that edge r1, r2, budjet, avgtalk, avgdata SHALL be captured and held for the whole scan; index counter cleared to 0; running best cleared.
REQ-019 In SCAN the block SHALL evaluate exactly one plan per cycle, index 0 upward, using a single shared multiply-add: score = talk*r1 + data*r2, zero-extended to 16 bits (max 882, no overflow).
REQ-020 A plan SHALL be eligible iff cost <= budjet and talk >= avgtalk and data >= avgdata (unsigned compares).
REQ-021 An eligible plan SHALL replace the running best only if its score is strictly greater; ties keep the lower index; an eligible plan with score 0 is still selectable when no prior eligible plan exists.
REQ-022 SCAN->DONE after the cycle evaluating index NPLAN-1 (SCAN lasts exactly NPLAN cycles).
REQ-023 In DONE (one cycle) sel, none, best_score SHALL update and done SHALL be 1; DONE->IDLE unconditionally.
REQ-024 Latency: done asserted NPLAN+1 cycles after the edge that accepted start.
REQ-025 sel/none/best_score SHALL hold their value from DONE until the next DONE.
REQ-026 start during SCAN or DONE SHALL be ignored (not queued); start held high in IDLE re-triggers a new scan each time IDLE is reached.
REQ-027 Changes to r1/r2/limit inputs during SCAN SHALL NOT affect the running scan.

Reset
REQ-028 On rst_n=0: state IDLE, busy=0, done=0, sel=0, none=1, best_score=0, counter=0, all table entries cost=all-ones, talk=0, data=0.
REQ-029 Reset asserted mid-scan SHALL abort it with no done pulse; outputs take reset values immediately.

Verification
REQ-030 Plans (cost,talk,data)={(10,20,30),(40,50,50),(20,30,40),(5,5,5),(60,60,60)}, r1=2,r2=1, budjet=30,avgtalk=10,avgdata=10, start -> done after 6 cycles, sel=00100, best_score=100, none=0.
REQ-031 Same table, budjet=4 -> sel=00000, none=1, best_score=0.
REQ-032 Plans 1 and 3 both eligible with score 50, others ineligible -> sel=00010 (lower index wins).
REQ-033 Change budjet and write plan 2 during SCAN -> result equals pre-start values; table entry 2 unchanged afterwards.
REQ-034 Assert rst_n=0 in third SCAN cycle -> no done pulse, none=1, sel=0, busy=0; subsequent start after release runs a full scan.
REQ-035 start held high continuously -> done pulses every NPLAN+2 cycles; start pulsed during busy -> no extra scan.
